// File: rtl/video_pkg.sv
// Shared video types and default geometry for the scanline fetch path.
// Contents: pixel_t (RGB444 packed {r,g,b}), default source geometry,
// and the fetch FSM state encoding.
package video_pkg;
    localparam int COLOR_W_DEF = 12;
    localparam int SRC_W_DEF   = 160;
    localparam int SRC_H_DEF   = 120;
    localparam int SCALE_DEF   = 4;
    localparam int ADDR_W_DEF  = 16;

    typedef logic [COLOR_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;
endpackage

// File: rtl/scanline_fetch_if.sv
// Read-request / read-response memory port used by the scanline fetcher.
// master: issues req_valid/req_addr, consumes req_ready and in-order responses.
// slave : the memory side.
interface scanline_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int COLOR_W = 12
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [COLOR_W-1:0] resp_data;

    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: two banks of DEPTH pixels, one write port and one
// registered read port, each with its own bank select.
// Ports: clk; wr_bank/wr_addr/wr_data/wr_en; rd_bank/rd_addr -> rd_data (1 cycle).
module line_buffer_pp #(
    parameter int DEPTH  = 160,
    parameter int DATA_W = 12,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2][DEPTH];

    // Contents are not reset; the read side gates unfetched data out.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end
endmodule

// File: rtl/scanline_fetch.sv
// Scanline fetcher: pulls source rows over the memory port into the back
// bank of a ping-pong line buffer while the front bank feeds the display.
// Ports: pixel_clk, rst (sync, active-high); frame_start, line_end, next_y
// (fetch triggers); pix_x, pix_de -> pix_rgb (1-cycle latency); mem (memory
// port, master side); underrun (sticky, set when a swap beats the fetch).
module scanline_fetch
    import video_pkg::*;
#(
    parameter int SRC_W   = SRC_W_DEF,
    parameter int SRC_H   = SRC_H_DEF,
    parameter int SCALE   = SCALE_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               line_end,
    input  logic [9:0]         next_y,
    input  logic [9:0]         pix_x,
    input  logic               pix_de,
    output logic [COLOR_W-1:0] pix_rgb,
    scanline_fetch_if.master   mem,
    output logic               underrun
);
    localparam int CW = $clog2(SRC_W + 1);
    localparam int BW = $clog2(SRC_W);
    localparam int RW = $clog2(SRC_H);
    localparam logic [9:0] SCALE_V = 10'(SCALE);

    fetch_state_t state, state_next;
    logic          front_sel, show_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] req_col, resp_cnt, discard;
    logic [CW-1:0] cur_out, discard_dec, stale_sat;
    logic [CW:0]   stale_sum;
    logic [9:0]    src_x, ny_div, next_row;
    logic          in_range, swap_line, busy, abort, start;
    logic          issue, resp_drop, resp_wr;
    logic [COLOR_W-1:0] rd_data;
    logic [63:0]   addr_full;

    // Read side
    assign src_x    = pix_x / SCALE_V;
    assign in_range = pix_de && (src_x < 10'(SRC_W));
    assign pix_rgb  = show_q ? rd_data : '0;

    // Trigger decode; frame_start masks a coincident line_end entirely
    assign ny_div    = next_y / SCALE_V;
    assign next_row  = ny_div + 10'd1;
    assign swap_line = line_end && !frame_start && ((next_y % SCALE_V) == 10'd0)
                       && (ny_div < 10'(SRC_H));
    assign busy      = (state != IDLE);
    assign abort     = busy && (frame_start || swap_line);
    assign start     = frame_start || (swap_line && (next_row < 10'(SRC_H)));

    // Memory handshake
    assign mem.req_valid = (state == REQ);
    assign mem.req_addr  = ADDR_W'(row_q) * ADDR_W'(SRC_W) + ADDR_W'(req_col);
    assign issue     = (state == REQ) && mem.req_ready;
    // Responses are in order: the first `discard` of them belong to an aborted fetch
    assign resp_drop = mem.resp_valid && (discard != '0);
    assign resp_wr   = mem.resp_valid && (discard == '0) && busy && (resp_cnt < CW'(SRC_W));

    // On abort every in-flight response of the current fetch becomes stale,
    // including a request accepted on the abort cycle itself.
    assign cur_out     = (req_col + CW'(issue)) - (resp_cnt + CW'(resp_wr));
    assign discard_dec = discard - CW'(resp_drop);
    assign stale_sum   = (CW+1)'(discard_dec) + (CW+1)'(cur_out);
    assign stale_sat   = (stale_sum > (CW+1)'(SRC_W)) ? CW'(SRC_W) : stale_sum[CW-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    ;
            REQ:     if (issue && req_col == CW'(SRC_W - 1)) state_next = DRAIN;
            DRAIN:   if (resp_cnt == CW'(SRC_W)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (start)
            state_next = REQ;
        else if (abort)
            state_next = IDLE;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            show_q    <= 1'b0;
            row_q     <= '0;
            req_col   <= '0;
            resp_cnt  <= '0;
            discard   <= '0;
            underrun  <= 1'b0;
        end else begin
            state   <= state_next;
            show_q  <= in_range;
            discard <= abort ? stale_sat : discard_dec;
            if (swap_line) begin
                front_sel <= ~front_sel;
                if (busy)
                    underrun <= 1'b1;
            end
            if (start) begin
                row_q    <= frame_start ? '0 : next_row[RW-1:0];
                req_col  <= '0;
                resp_cnt <= '0;
            end else begin
                if (issue)   req_col  <= req_col + CW'(1);
                if (resp_wr) resp_cnt <= resp_cnt + CW'(1);
            end
        end
    end

    // Geometry must keep every row*SRC_W + col inside the address space
    assign addr_full = 64'(row_q) * 64'(SRC_W) + 64'(req_col);
    always @(posedge pixel_clk) begin
        if (!rst && state == REQ)
            assert (addr_full < (64'd1 << ADDR_W));
    end

    line_buffer_pp #(.DEPTH(SRC_W), .DATA_W(COLOR_W)) u_lbuf (
        .clk     (pixel_clk),
        .wr_bank (~front_sel),
        .wr_addr (resp_cnt[BW-1:0]),
        .wr_data (mem.resp_data),
        .wr_en   (resp_wr),
        .rd_bank (front_sel),
        .rd_addr (src_x[BW-1:0]),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_scanline_fetch.sv
// Bench for scanline_fetch: behavioural memory (mem[a] = a[11:0], in-order
// responses with configurable latency and ready pattern) plus a table of
// pixel read vectors and hand-written fetch/abort/reset sequences.
module tb_scanline_fetch;
    import video_pkg::*;
    localparam int SRC_W = 160, ADDR_W = 16, COLOR_W = 12;

    logic clk = 1'b1;
    logic rst, frame_start, line_end, pix_de, underrun;
    logic [9:0] next_y, pix_x;
    logic [COLOR_W-1:0] pix_rgb;

    scanline_fetch_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) mem_if ();

    scanline_fetch dut (
        .pixel_clk   (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .line_end    (line_end),
        .next_y      (next_y),
        .pix_x       (pix_x),
        .pix_de      (pix_de),
        .pix_rgb     (pix_rgb),
        .mem         (mem_if),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    // ---------------- memory model (acts at negedge for the next posedge)
    typedef struct { int due; pixel_t data; } resp_t;
    resp_t rq[$];
    logic [ADDR_W-1:0] req_log[$];
    int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, stall_err = 0;
    bit rand_ready = 0, chk_stable = 0, prev_stall = 0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        int d;
        if (chk_stable && prev_stall && (!mem_if.req_valid || mem_if.req_addr != prev_addr))
            stall_err++;
        mem_if.req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc++;
        if (rst) begin
            rq.delete();
            last_due = 0;
            mem_if.resp_valid = 1'b0;
            mem_if.resp_data  = '0;
        end else begin
            if (mem_if.req_valid && mem_if.req_ready) begin
                d = cyc + int'($urandom_range(lat_min, lat_max));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                rq.push_back('{d, mem_if.req_addr[COLOR_W-1:0]});
                req_log.push_back(mem_if.req_addr);
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                mem_if.resp_valid = 1'b1;
                mem_if.resp_data  = rq[0].data;
                void'(rq.pop_front());
            end else begin
                mem_if.resp_valid = 1'b0;
                mem_if.resp_data  = COLOR_W'($urandom);
            end
        end
        prev_stall = mem_if.req_valid && !mem_if.req_ready;
        prev_addr  = mem_if.req_addr;
    end

    // ---------------- helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input bit fs, input bit le, input int y);
        frame_start = fs; line_end = le; next_y = 10'(y);
        tick();
        frame_start = 0; line_end = 0;
    endtask

    task automatic wait_fetch(input string name);
        int k = 0;
        while (k < 3000 && !(req_log.size() >= SRC_W && rq.size() == 0 && !mem_if.req_valid)) begin
            tick();
            k++;
        end
        chk({name, " fetch completes in budget"}, 32'(k < 3000), 1);
        tick(3);
    endtask

    task automatic check_log(input string name, input int base);
        int bad = 0;
        int n = req_log.size();
        if (n < SRC_W) bad = SRC_W;
        else for (int i = 0; i < SRC_W; i++)
            if (int'(req_log[n - SRC_W + i]) != base + i) bad++;
        chk({name, " address sequence errors"}, 32'(bad), 0);
    endtask

    // ---------------- pixel read vectors
    typedef struct { int ph; logic [9:0] x; logic de; logic [11:0] exp; } vec_t;
    vec_t tbl[$];

    task automatic add(input int ph, input int x, input bit de, input int exp);
        tbl.push_back('{ph, 10'(x), de, 12'(exp)});
    endtask

    task automatic run_vecs(input int ph);
        foreach (tbl[i]) if (tbl[i].ph == ph) begin
            pix_x = tbl[i].x; pix_de = tbl[i].de;
            tick();
            chk($sformatf("pix ph%0d x=%0d de=%0b", ph, tbl[i].x, tbl[i].de), 32'(pix_rgb), 32'(tbl[i].exp));
        end
        pix_de = 0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        // row 0 in front
        add(1, 8, 1, 12'h002);  add(1, 0, 1, 12'h000);  add(1, 11, 1, 12'h002);
        add(1, 12, 1, 12'h003); add(1, 639, 1, 12'h09F); add(1, 640, 1, 12'h000);
        add(1, 700, 1, 12'h000); add(1, 8, 0, 12'h000);  add(1, 1023, 1, 12'h000);
        // row 1 in front, first pixels after the swap
        add(2, 12, 1, 12'h0A3); add(2, 0, 1, 12'h0A0);  add(2, 639, 1, 12'h13F);
        add(2, 700, 1, 12'h000); add(2, 12, 0, 12'h000);
        // row 3 in front
        add(3, 0, 1, 12'h1E0);  add(3, 308, 1, 12'h22D); add(3, 639, 1, 12'h27F);
        // row 6 in front (after the underrun)
        add(4, 0, 1, 12'h3C0);  add(4, 40, 1, 12'h3CA);  add(4, 639, 1, 12'h45F);
        // row 0 in front after reset and refetch
        add(5, 8, 1, 12'h002);  add(5, 639, 1, 12'h09F);

        rst = 1; frame_start = 0; line_end = 0; next_y = 0; pix_x = 0; pix_de = 0;
        tick(3);
        chk("reset pix_rgb", 32'(pix_rgb), 0);
        chk("reset req_valid", 32'(mem_if.req_valid), 0);
        chk("reset req_addr", 32'(mem_if.req_addr), 0);
        chk("reset underrun", 32'(underrun), 0);
        rst = 0;
        tick();

        // Row 0 at frame start, then row 1 after the y=0 swap
        req_log.delete(); pulse(1, 0, 0); wait_fetch("frame row0");
        check_log("frame row0", 0);
        chk("frame row0 request count", 32'(req_log.size()), SRC_W);
        req_log.delete(); pulse(0, 1, 0); wait_fetch("y0 row1");
        check_log("y0 row1", 160);
        run_vecs(1);
        chk("underrun after clean fetches", 32'(underrun), 0);

        // Non-boundary line ends do nothing
        req_log.delete();
        pulse(0, 1, 1); pulse(0, 1, 2); pulse(0, 1, 3); tick(4);
        chk("no fetch on y%4!=0", 32'(req_log.size()), 0);
        chk("no req_valid on y%4!=0", 32'(mem_if.req_valid), 0);
        pix_x = 8; pix_de = 1; tick(); pix_de = 0;
        chk("front unchanged on y%4!=0", 32'(pix_rgb), 12'h002);

        // y=4: swap to row 1, fetch row 2
        req_log.delete(); pulse(0, 1, 4);
        run_vecs(2);
        wait_fetch("y4 row2");
        check_log("y4 row2", 320);
        chk("underrun after y4", 32'(underrun), 0);

        // Random ready stalls, latency 1..8
        rand_ready = 1; lat_min = 1; lat_max = 8; chk_stable = 1; stall_err = 0;
        req_log.delete(); pulse(0, 1, 8); wait_fetch("stall row3");
        check_log("stall row3", 480);
        chk("stall row3 request count", 32'(req_log.size()), SRC_W);
        req_log.delete(); pulse(0, 1, 12);
        run_vecs(3);
        wait_fetch("stall row4");
        check_log("stall row4", 640);
        chk("addr/valid held while stalled", 32'(stall_err), 0);
        rand_ready = 0; chk_stable = 0; lat_max = 1;

        // Long latency: swap mid-fetch -> underrun, stale data discarded
        lat_min = 300; lat_max = 300;
        req_log.delete(); pulse(0, 1, 16);
        tick(50);
        chk("underrun before mid-fetch swap", 32'(underrun), 0);
        pulse(0, 1, 20);
        chk("underrun after mid-fetch swap", 32'(underrun), 1);
        wait_fetch("after abort row6");
        check_log("after abort row6", 960);
        lat_min = 1; lat_max = 1;
        req_log.delete(); pulse(0, 1, 24);
        run_vecs(4);
        wait_fetch("row7");
        chk("underrun sticky", 32'(underrun), 1);

        // frame_start and line_end together: fetch row 0, no swap
        req_log.delete(); pulse(1, 1, 28);
        pix_x = 0; pix_de = 1; tick(); pix_de = 0;
        chk("no swap when frame_start wins", 32'(pix_rgb), 12'h3C0);
        wait_fetch("fs+le row0");
        check_log("fs+le row0", 0);

        // Reset in the middle of a fetch
        req_log.delete(); pulse(0, 1, 28);
        k = 0;
        while (req_log.size() < 50 && k < 500) begin tick(); k++; end
        chk("reached col 50 in budget", 32'(k < 500), 1);
        chk("mid-fetch req_valid before rst", 32'(mem_if.req_valid), 1);
        pix_x = 8; pix_de = 1; tick();
        chk("pix_rgb nonzero before rst", 32'(pix_rgb), 12'h002);
        rst = 1; tick(); 
        chk("rst req_valid", 32'(mem_if.req_valid), 0);
        chk("rst pix_rgb", 32'(pix_rgb), 0);
        chk("rst underrun", 32'(underrun), 0);
        chk("rst req_addr", 32'(mem_if.req_addr), 0);
        rst = 0; pix_de = 0;
        tick(5);
        chk("idle after rst", 32'(mem_if.req_valid), 0);

        // Normal operation after reset
        req_log.delete(); pulse(1, 0, 0); wait_fetch("post-rst row0");
        check_log("post-rst row0", 0);
        req_log.delete(); pulse(0, 1, 0); wait_fetch("post-rst row1");
        run_vecs(5);
        chk("post-rst underrun", 32'(underrun), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
